round_ctrl: RTL and testbench
=============================

// Module: round_ctrl
// PURPOSE
// Per-round sequencer for the two-player reaction game: random pre-go wait,
// GO lamp, first-press arbitration, fouls, scoring and round counting. Drives
// is_final to the inter-round delay block and waits on its is_wait /
// is_final_finish before starting the next round or closing the match.
// PARAMETERS
// ROUNDS      5           rounds per match (1..15)
// MIN_WAIT    25_000_000  fixed part of pre-go wait, clk cycles
// RAND_BITS   8           LFSR bits used for random extra wait
// RAND_SHIFT  17          extra wait = lfsr[RAND_BITS-1:0] << RAND_SHIFT
// GO_TIMEOUT  100_000_000 cycles GO stays lit before round is void
// PORTS
// clk             in  1  system clock
// rst             in  1  synchronous reset, active-high
// start           in  1  1-cycle pulse: begin match (used only in IDLE)
// key1            in  1  player 1 pressed, active-high, already synced
// key2            in  1  player 2 pressed, active-high, already synced
// is_wait         in  1  delay block: 0 while inter-round pause runs, 1 idle
// is_final_finish in  1  delay block: final pause complete
// is_final        out 1  1 while current round == ROUNDS
// go_led          out 1  GO lamp
// round_no        out 4  current round, 1..ROUNDS; 0 in IDLE
// score1, score2  out 4  points per player
// foul1, foul2    out 1  registered foul flag for the round just scored
// round_done      out 1  1-cycle pulse when a round result is registered
// match_over      out 1  held high in DONE
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, counter 0, LFSR = 16'hACE1.
// - LFSR: 16-bit Fibonacci, taps 16,14,13,11, steps every cycle, never 0.
// - 28-bit cycle counter cnt shared by all timed states; cleared on each entry.
// - IDLE: start=1 -> round_no<=1, scores<=0, load wait target, go RAND_WAIT.
// - RAND_WAIT: target = MIN_WAIT + (lfsr[RAND_BITS-1:0]<<RAND_SHIFT), latched
//   on entry. key press here = foul: key1 -> foul1=1, score2+1; key2 -> foul2,
//   score1+1; both same cycle -> both fouls, no score. -> SCORE.
//   cnt reaches target-1 with no key -> GO (go_led=1 next cycle).
// - GO: go_led=1. First cycle with key1 only -> score1+1; key2 only ->
//   score2+1; both same cycle -> tie, no score. cnt == GO_TIMEOUT-1 -> void,
//   no score. Any exit -> SCORE, go_led<=0.
// - Keys already held when entering GO count as presses in the first cycle.
// - SCORE (1 cycle): round_done=1, scores updated, saturate at 15.
//   -> HOLD.
// - HOLD: wait for is_wait==0 (pause started), then is_wait==1 (pause over).
//   If round_no < ROUNDS: round_no+1, clear fouls, -> RAND_WAIT.
//   If round_no == ROUNDS: -> FINAL_HOLD.
// - FINAL_HOLD: wait is_final_finish==1 -> DONE.
// - DONE: match_over=1, scores/round_no frozen; only rst leaves (start ignored).
// - is_final combinational from registered round_no; low in IDLE.
// - start ignored outside IDLE. rst in any state, incl. mid-GO: outputs to
//   reset values next cycle, go_led drops immediately on that edge.
// TESTING (ROUNDS=2, MIN_WAIT=10, RAND_BITS=2, RAND_SHIFT=1, GO_TIMEOUT=20)
// - rst, start pulse -> round_no=1, go_led=1 within 10..16 cycles, is_final=0.
// - GO, key1 pulse -> round_done 1 cycle, score1=1, score2=0, go_led=0.
// - key2 during RAND_WAIT -> foul2=1, score1+1, go_led never rises that round.
// - key1&key2 same cycle in GO -> scores unchanged, round_done=1.
// - no key in GO for 20 cycles -> void round, go_led=0, scores unchanged.
// - round 2: is_final=1; is_wait 1->0->1 then is_final_finish=1 -> match_over=1;
//   later start ignored; rst mid-GO -> all outputs 0 next cycle.

Source files
------------

// File: rtl/round_ctrl.sv
// -----------------------------------------------------------------------------
// round_ctrl
// Round sequencer for a two-player reaction game. Each round waits a
// pseudo-random time, lights the GO lamp, decides who pressed first (or who
// jumped the gun), registers the result, then hands off to an external
// inter-round delay block before the next round. After the last round it
// waits for the delay block's final pause and holds the match result.
//
// Ports
//   clk             in   system clock
//   rst             in   synchronous reset, active-high
//   start           in   1-cycle pulse, begins a match (only honoured in IDLE)
//   key1, key2      in   player buttons, active-high, already synchronised
//   is_wait         in   delay block: 0 while the inter-round pause runs
//   is_final_finish in   delay block: final pause complete
//   is_final        out  high while the current round is the last one
//   go_led          out  GO lamp
//   round_no        out  current round 1..ROUNDS, 0 when idle
//   score1, score2  out  points per player, saturating at 15
//   foul1, foul2    out  foul flags for the round just scored
//   round_done      out  1-cycle pulse while a round result is presented
//   match_over      out  held high once the match is complete
// -----------------------------------------------------------------------------
module round_ctrl #(
  parameter int ROUNDS     = 5,
  parameter int MIN_WAIT   = 25_000_000,
  parameter int RAND_BITS  = 8,
  parameter int RAND_SHIFT = 17,
  parameter int GO_TIMEOUT = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       key1,
  input  logic       key2,
  input  logic       is_wait,
  input  logic       is_final_finish,
  output logic       is_final,
  output logic       go_led,
  output logic [3:0] round_no,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       foul1,
  output logic       foul2,
  output logic       round_done,
  output logic       match_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAND_WAIT,
    S_GO,
    S_SCORE,
    S_HOLD,
    S_FINAL_HOLD,
    S_DONE
  } state_e;

  localparam logic [27:0] MinWait   = 28'(MIN_WAIT);
  localparam logic [27:0] GoLast    = 28'(GO_TIMEOUT - 1);
  localparam logic [3:0]  LastRound = 4'(ROUNDS);
  localparam logic [15:0] LfsrSeed  = 16'hACE1;

  state_e      state_q, state_d;
  logic [27:0] cnt_q, cnt_d;
  logic [27:0] target_q, target_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  round_q, round_d;
  logic [3:0]  score1_q, score1_d;
  logic [3:0]  score2_q, score2_d;
  logic        foul1_q, foul1_d;
  logic        foul2_q, foul2_d;
  logic        go_q, go_d;
  logic        over_q, over_d;
  logic        saw_low_q, saw_low_d;   // HOLD has seen the pause begin
  logic [27:0] wait_target;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Taps 16,14,13,11; a non-zero seed keeps it out of the all-zero lock-up.
  assign lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign wait_target = MinWait + (28'(lfsr_q[RAND_BITS-1:0]) << RAND_SHIFT);

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    target_d  = target_q;
    round_d   = round_q;
    score1_d  = score1_q;
    score2_d  = score2_q;
    foul1_d   = foul1_q;
    foul2_d   = foul2_q;
    go_d      = go_q;
    over_d    = over_q;
    saw_low_d = saw_low_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          round_d  = 4'd1;
          score1_d = 4'd0;
          score2_d = 4'd0;
          foul1_d  = 1'b0;
          foul2_d  = 1'b0;
          target_d = wait_target;
          cnt_d    = '0;
          state_d  = S_RAND_WAIT;
        end
      end

      S_RAND_WAIT: begin
        // A press before GO is a foul and awards the opponent; a key check
        // takes priority over the wait expiring in the same cycle.
        if (key1 || key2) begin
          foul1_d = key1;
          foul2_d = key2;
          if (key1 && !key2) score2_d = sat_inc(score2_q);
          if (key2 && !key1) score1_d = sat_inc(score1_q);
          state_d = S_SCORE;
        end else if (cnt_q == target_q - 28'd1) begin
          go_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_GO;
        end else begin
          cnt_d = cnt_q + 28'd1;
        end
      end

      S_GO: begin
        if (key1 || key2 || cnt_q == GoLast) begin
          if (key1 && !key2) score1_d = sat_inc(score1_q);
          if (key2 && !key1) score2_d = sat_inc(score2_q);
          go_d    = 1'b0;
          state_d = S_SCORE;
        end else begin
          cnt_d = cnt_q + 28'd1;
        end
      end

      S_SCORE: begin
        saw_low_d = 1'b0;
        state_d   = S_HOLD;
      end

      S_HOLD: begin
        // Only a full low-then-high cycle of is_wait ends the pause.
        if (!saw_low_q) begin
          if (!is_wait) saw_low_d = 1'b1;
        end else if (is_wait) begin
          if (round_q < LastRound) begin
            round_d  = round_q + 4'd1;
            foul1_d  = 1'b0;
            foul2_d  = 1'b0;
            target_d = wait_target;
            cnt_d    = '0;
            state_d  = S_RAND_WAIT;
          end else begin
            state_d = S_FINAL_HOLD;
          end
        end
      end

      S_FINAL_HOLD: begin
        if (is_final_finish) begin
          over_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE:  ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      target_q  <= '0;
      lfsr_q    <= LfsrSeed;
      round_q   <= '0;
      score1_q  <= '0;
      score2_q  <= '0;
      foul1_q   <= 1'b0;
      foul2_q   <= 1'b0;
      go_q      <= 1'b0;
      over_q    <= 1'b0;
      saw_low_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      lfsr_q    <= lfsr_d;
      round_q   <= round_d;
      score1_q  <= score1_d;
      score2_q  <= score2_d;
      foul1_q   <= foul1_d;
      foul2_q   <= foul2_d;
      go_q      <= go_d;
      over_q    <= over_d;
      saw_low_q <= saw_low_d;
    end
  end

  assign is_final   = (round_q == LastRound);
  assign go_led     = go_q;
  assign round_no   = round_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign foul1      = foul1_q;
  assign foul2      = foul2_q;
  assign round_done = (state_q == S_SCORE);
  assign match_over = over_q;

endmodule

// File: tb/tb_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_round_ctrl
// Plays several short matches (ROUNDS=2) with randomly chosen round outcomes
// and random timing, comparing every output against a scoreboard of the
// expected game state. The pre-go wait is predicted from a generator-level
// model of the 16-bit LFSR sequence.
// -----------------------------------------------------------------------------
module tb_round_ctrl;

  localparam int ROUNDS     = 2;
  localparam int MIN_WAIT   = 10;
  localparam int RAND_BITS  = 2;
  localparam int RAND_SHIFT = 1;
  localparam int GO_TIMEOUT = 20;

  // Round outcome kinds
  localparam int K_P1 = 0, K_P2 = 1, K_TIE = 2, K_VOID = 3;
  localparam int K_FOUL1 = 4, K_FOUL2 = 5, K_FOUL_BOTH = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, key1 = 1'b0, key2 = 1'b0;
  logic       is_wait = 1'b1, is_final_finish = 1'b0;
  logic       is_final, go_led, foul1, foul2, round_done, match_over;
  logic [3:0] round_no, score1, score2;

  always #5 clk = ~clk;

  round_ctrl #(
    .ROUNDS(ROUNDS), .MIN_WAIT(MIN_WAIT), .RAND_BITS(RAND_BITS),
    .RAND_SHIFT(RAND_SHIFT), .GO_TIMEOUT(GO_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .key1(key1), .key2(key2),
    .is_wait(is_wait), .is_final_finish(is_final_finish),
    .is_final(is_final), .go_led(go_led), .round_no(round_no),
    .score1(score1), .score2(score2), .foul1(foul1), .foul2(foul2),
    .round_done(round_done), .match_over(match_over)
  );

  // Random-sequence model: the generator state the game draws from this cycle.
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  // Scoreboard of the expected game state
  int exp_round, exp_s1, exp_s2, exp_f1, exp_f2, exp_go, exp_done, exp_over;
  int cur_tgt;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int wait_cycles();
    return MIN_WAIT + int'(m_lfsr[RAND_BITS-1:0]) * (2 ** RAND_SHIFT);
  endfunction

  function automatic int bump(input int s);
    return (s < 15) ? s + 1 : 15;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".round_no"},   32'(round_no),   exp_round);
    check({tag, ".score1"},     32'(score1),     exp_s1);
    check({tag, ".score2"},     32'(score2),     exp_s2);
    check({tag, ".foul1"},      32'(foul1),      exp_f1);
    check({tag, ".foul2"},      32'(foul2),      exp_f2);
    check({tag, ".go_led"},     32'(go_led),     exp_go);
    check({tag, ".round_done"}, 32'(round_done), exp_done);
    check({tag, ".match_over"}, 32'(match_over), exp_over);
    check({tag, ".is_final"},   32'(is_final),   (exp_round == ROUNDS) ? 1 : 0);
  endtask

  task automatic clear_model();
    exp_round = 0; exp_s1 = 0; exp_s2 = 0; exp_f1 = 0; exp_f2 = 0;
    exp_go = 0; exp_done = 0; exp_over = 0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; start = 1'b0; key1 = 1'b0; key2 = 1'b0;
    is_wait = 1'b1; is_final_finish = 1'b0;
    step();
    rst = 1'b0;
    clear_model();
    check_outputs(tag);
  endtask

  task automatic start_match();
    start   = 1'b1;
    cur_tgt = wait_cycles();
    step();
    start     = 1'b0;
    exp_round = 1;
    check_outputs("start");
  endtask

  // Entered with the DUT in its first pre-go wait cycle; cur_tgt cycles remain.
  task automatic play_round(input int kind);
    int d;
    if (kind >= K_FOUL1) begin
      d = $urandom_range(0, cur_tgt - 1);
      repeat (d) begin
        step();
        check("foul_wait.go_led", 32'(go_led), 0);
      end
      key1 = (kind == K_FOUL1 || kind == K_FOUL_BOTH);
      key2 = (kind == K_FOUL2 || kind == K_FOUL_BOTH);
      step();
      exp_f1 = (kind == K_FOUL1 || kind == K_FOUL_BOTH) ? 1 : 0;
      exp_f2 = (kind == K_FOUL2 || kind == K_FOUL_BOTH) ? 1 : 0;
      if (kind == K_FOUL1) exp_s2 = bump(exp_s2);
      if (kind == K_FOUL2) exp_s1 = bump(exp_s1);
    end else begin
      repeat (cur_tgt - 1) begin
        step();
        check("pre_go.go_led", 32'(go_led), 0);
      end
      step();
      check("go_rise.go_led", 32'(go_led), 1);
      if (kind == K_VOID) begin
        repeat (GO_TIMEOUT - 1) step();
        check("go_last.go_led", 32'(go_led), 1);
        step();
      end else begin
        d = $urandom_range(0, 4);
        repeat (d) step();
        key1 = (kind == K_P1 || kind == K_TIE);
        key2 = (kind == K_P2 || kind == K_TIE);
        step();
        if (kind == K_P1) exp_s1 = bump(exp_s1);
        if (kind == K_P2) exp_s2 = bump(exp_s2);
      end
    end
    exp_go = 0; exp_done = 1;
    check_outputs("score");
    key1 = 1'b0; key2 = 1'b0;
    step();
    exp_done = 0;
    check_outputs("hold");

    // Inter-round pause handshake: high (idle), low (running), high (over).
    repeat ($urandom_range(0, 3)) step();
    check_outputs("hold_idle");
    is_wait = 1'b0;
    repeat ($urandom_range(1, 3)) step();
    check_outputs("hold_pause");
    is_wait = 1'b1;
    cur_tgt = wait_cycles();
    step();
    if (exp_round < ROUNDS) begin
      exp_round++;
      exp_f1 = 0; exp_f2 = 0;
      check_outputs("next_round");
    end else begin
      check_outputs("final_hold");
    end
  endtask

  task automatic finish_match();
    repeat ($urandom_range(0, 3)) step();
    check_outputs("final_wait");
    is_final_finish = 1'b1;
    step();
    is_final_finish = 1'b0;
    exp_over = 1;
    check_outputs("done");
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_outputs("start_ignored");
  endtask

  int kinds [4][ROUNDS] = '{'{K_P1, K_FOUL2}, '{K_TIE, K_VOID},
                            '{K_P2, K_FOUL_BOTH}, '{K_FOUL1, K_P1}};

  initial begin
    clear_model();
    do_reset("reset");
    for (int m = 0; m < 8; m++) begin
      if (m > 0) do_reset("reset_between");
      start_match();
      for (int r = 0; r < ROUNDS; r++)
        play_round((m < 4) ? kinds[m][r] : int'($urandom_range(0, 6)));
      finish_match();
    end

    // Reset while the GO lamp is lit
    do_reset("reset_pre_go");
    start_match();
    repeat (cur_tgt) step();
    check("mid_go.go_led", 32'(go_led), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_model();
    check_outputs("reset_mid_go");
    step();
    check_outputs("idle_after_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
